id_stage_sequencer: RTL and testbench

- Sequences the IF and ID stages of the 5-stage MIPS pipeline.
- Decides every stall, bubble, IF/ID flush and PC-source selection from the instruction decoding in ID and the producers in EX and MEM.
- Freezes the whole pipeline while data memory is busy.
- Sits next to the ID-stage branch comparator and drives the PC mux, the IF/ID register enables and the ID/EX control-zeroing mux.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/hazard_need.sv | 45 ++++
 rtl/id_stage_sequencer.sv | 149 ++++++++++++++
 tb/tb_id_stage_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the IF/ID stage sequencer.
package pipeline_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } seq_state_e;

  localparam logic [1:0] PCSEL_SEQ    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_JUMP   = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_need.sv
// Combinational hazard classifier: number of stall cycles the ID instruction
// needs given the producers currently in EX and MEM.
module hazard_need
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic       branch_eq_id,
  input  logic       branch_ne_id,
  input  logic [4:0] dest_ex,
  input  logic [4:0] dest_mem,
  input  logic       reg_write_ex,
  input  logic       mem_read_ex,
  input  logic       mem_read_mem,
  output logic [1:0] need
);

  logic w_branch;
  logic w_match_ex;
  logic w_match_mem;

  assign w_branch    = branch_eq_id | branch_ne_id;
  assign w_match_ex  = (dest_ex != REG_ZERO) &&
                       ((dest_ex == rs_id) || (uses_rt_id && (dest_ex == rt_id)));
  assign w_match_mem = (dest_mem != REG_ZERO) &&
                       ((dest_mem == rs_id) || (uses_rt_id && (dest_mem == rt_id)));

  // The comparator sits in ID, so branches wait for results that ALU
  // instructions would simply forward; ALU results in MEM are forwarded.
  always_comb begin
    need = 2'd0;
    if (w_branch) begin
      if (mem_read_ex && w_match_ex)
        need = 2'd2;
      else if (reg_write_ex && !mem_read_ex && w_match_ex)
        need = 2'd1;
      else if (mem_read_mem && w_match_mem)
        need = 2'd1;
    end else if (mem_read_ex && w_match_ex) begin
      need = 2'd1;
    end
  end

endmodule

// File: rtl/id_stage_sequencer.sv
// IF/ID stage sequencer: stalls, bubbles, IF/ID flush, PC source and memory freeze.
// Optional PERF_COUNTERS_EN adds saturating stall/flush/freeze counters.
//
// state | meaning
// RUN   | normal issue; hazards evaluated, redirects allowed
// STALL | second cycle of a branch-behind-load stall; hazards not re-evaluated
module id_stage_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             branch_eq_id,
  input  logic             branch_ne_id,
  input  logic             jump_id,
  input  logic             regs_equal_id,
  input  logic [4:0]       dest_ex,
  input  logic [4:0]       dest_mem,
  input  logic             reg_write_ex,
  input  logic             mem_read_ex,
  input  logic             mem_read_mem,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze,
  output logic [1:0]       pc_sel,
  output logic             stall_active
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles
`endif
);

  seq_state_e r_state;
  logic [1:0] r_remain;
  logic [1:0] w_need;
  logic       w_freeze;
  logic       w_taken;

  hazard_need u_hazard_need (
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .uses_rt_id   (uses_rt_id),
    .branch_eq_id (branch_eq_id),
    .branch_ne_id (branch_ne_id),
    .dest_ex      (dest_ex),
    .dest_mem     (dest_mem),
    .reg_write_ex (reg_write_ex),
    .mem_read_ex  (mem_read_ex),
    .mem_read_mem (mem_read_mem),
    .need         (w_need)
  );

  assign w_freeze = dmem_req && !dmem_ready;
  assign w_taken  = (branch_eq_id && regs_equal_id) || (branch_ne_id && !regs_equal_id);

  // Outputs are gated by rst_n so an asserted reset clears them immediately.
  always_comb begin
    hold_pc      = 1'b0;
    hold_if_id   = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    freeze       = 1'b0;
    pc_sel       = PCSEL_SEQ;
    stall_active = 1'b0;
    if (rst_n) begin
      stall_active = (r_state == STALL);
      if (w_freeze) begin
        freeze     = 1'b1;
        hold_pc    = 1'b1;
        hold_if_id = 1'b1;
      end else if ((r_state == STALL) || (w_need != 2'd0)) begin
        hold_pc      = 1'b1;
        hold_if_id   = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (jump_id) begin
        pc_sel      = PCSEL_JUMP;
        flush_if_id = 1'b1;
      end else if (w_taken) begin
        pc_sel      = PCSEL_BRANCH;
        flush_if_id = 1'b1;
      end
    end
  end

  // A freeze holds state and remain, stretching any stall by its length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_remain <= 2'd0;
    end else if (!w_freeze) begin
      case (r_state)
        RUN: begin
          if (w_need == 2'd2) begin
            r_state  <= STALL;
            r_remain <= 2'd1;
          end
        end
        STALL: begin
          if (r_remain <= 2'd1) begin
            r_state  <= RUN;
            r_remain <= 2'd0;
          end else begin
            r_remain <= r_remain - 2'd1;
          end
        end
        default: begin
          r_state  <= RUN;
          r_remain <= 2'd0;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_freeze_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_freeze_cycles <= '0;
    end else begin
      if (bubble_id_ex && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (flush_if_id && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
      if (freeze && (r_freeze_cycles != '1))
        r_freeze_cycles <= r_freeze_cycles + 1'b1;
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign flush_count   = r_flush_count;
  assign freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_id_stage_sequencer.sv
// Directed bench for id_stage_sequencer; outputs packed as
// {hold_pc, hold_if_id, bubble, flush, freeze, pc_sel[1:0], stall_active}.
module tb_id_stage_sequencer;

  localparam logic [7:0] IDLE      = 8'b0000_0000;
  localparam logic [7:0] STALLV    = 8'b1110_0000;
  localparam logic [7:0] STALLS    = 8'b1110_0001;
  localparam logic [7:0] FRZ_RUN   = 8'b1100_1000;
  localparam logic [7:0] FRZ_STALL = 8'b1100_1001;
  localparam logic [7:0] BR        = 8'b0001_0010;
  localparam logic [7:0] JMP       = 8'b0001_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs_id, rt_id, dest_ex, dest_mem;
  logic       uses_rt_id, branch_eq_id, branch_ne_id, jump_id, regs_equal_id;
  logic       reg_write_ex, mem_read_ex, mem_read_mem, dmem_req, dmem_ready;
  logic       hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze, stall_active;
  logic [1:0] pc_sel;
`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cycles, flush_count, freeze_cycles;
`endif

  int checks = 0;
  int failures = 0;

  id_stage_sequencer #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs_id         (rs_id),
    .rt_id         (rt_id),
    .uses_rt_id    (uses_rt_id),
    .branch_eq_id  (branch_eq_id),
    .branch_ne_id  (branch_ne_id),
    .jump_id       (jump_id),
    .regs_equal_id (regs_equal_id),
    .dest_ex       (dest_ex),
    .dest_mem      (dest_mem),
    .reg_write_ex  (reg_write_ex),
    .mem_read_ex   (mem_read_ex),
    .mem_read_mem  (mem_read_mem),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .hold_pc       (hold_pc),
    .hold_if_id    (hold_if_id),
    .bubble_id_ex  (bubble_id_ex),
    .flush_if_id   (flush_if_id),
    .freeze        (freeze),
    .pc_sel        (pc_sel),
    .stall_active  (stall_active)
`ifdef PERF_COUNTERS_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .freeze_cycles (freeze_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze, pc_sel, stall_active};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs_id = 5'd0; rt_id = 5'd0; dest_ex = 5'd0; dest_mem = 5'd0;
    uses_rt_id = 1'b0; branch_eq_id = 1'b0; branch_ne_id = 1'b0; jump_id = 1'b0;
    regs_equal_id = 1'b0; reg_write_ex = 1'b0; mem_read_ex = 1'b0; mem_read_mem = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  // beq $5,$6 in ID
  task automatic beq56(input logic eq);
    rs_id = 5'd5; rt_id = 5'd6; uses_rt_id = 1'b1; branch_eq_id = 1'b1; regs_equal_id = eq;
  endtask

  // lw $5 in EX
  task automatic lw5_ex();
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; dest_ex = 5'd5;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; dest_ex = 5'd2; rs_id = 5'd2; jump_id = 1'b1;
    #2 chk("reset_outputs", IDLE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // load-use: lw $2 ; add $3,$2,$4
    nxt(); mem_read_ex = 1'b1; reg_write_ex = 1'b1; dest_ex = 5'd2;
    rs_id = 5'd2; rt_id = 5'd4; uses_rt_id = 1'b1;
    #1 chk("lu_stall", STALLV);
    nxt(); mem_read_mem = 1'b1; dest_mem = 5'd2; rs_id = 5'd2; rt_id = 5'd4; uses_rt_id = 1'b1;
    #1 chk("lu_resume", IDLE);
`ifdef PERF_COUNTERS_EN
    chk_cnt("cnt_stall_lu", stall_cycles, 32'd1);
`endif

    nxt(); mem_read_ex = 1'b1; reg_write_ex = 1'b1; dest_ex = 5'd0; rs_id = 5'd0;
    #1 chk("zero_reg", IDLE);
    nxt(); mem_read_ex = 1'b1; reg_write_ex = 1'b1; dest_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7;
    #1 chk("rt_unused", IDLE);
    uses_rt_id = 1'b1;
    #1 chk("rt_used", STALLV);
    nxt();
    #1 chk("after_rt", IDLE);

    // lw $5 ; beq $5,$6 : two stall cycles then taken
    nxt(); lw5_ex(); beq56(1'b1);
    #1 chk("beq_lw_c1", STALLV);
    nxt(); mem_read_mem = 1'b1; dest_mem = 5'd5; beq56(1'b1);
    #1 chk("beq_lw_c2", STALLS);
    nxt(); beq56(1'b1);
    #1 chk("beq_taken", BR);
    nxt();
    #1 chk("after_beq", IDLE);

    // add $5 ; bne $5,$0 : one stall then taken
    nxt(); reg_write_ex = 1'b1; dest_ex = 5'd5; rs_id = 5'd5; uses_rt_id = 1'b1; branch_ne_id = 1'b1;
    #1 chk("bne_alu_c1", STALLV);
    nxt(); dest_mem = 5'd5; rs_id = 5'd5; uses_rt_id = 1'b1; branch_ne_id = 1'b1;
    #1 chk("bne_taken", BR);
    nxt();
    #1 chk("after_bne", IDLE);

    // branch behind a load already in MEM
    nxt(); mem_read_mem = 1'b1; dest_mem = 5'd9; rs_id = 5'd1; rt_id = 5'd9;
    uses_rt_id = 1'b1; branch_eq_id = 1'b1;
    #1 chk("beq_memload", STALLV);
    nxt(); rs_id = 5'd1; rt_id = 5'd9; uses_rt_id = 1'b1; branch_eq_id = 1'b1;
    #1 chk("beq_not_taken", IDLE);

    // 3-cycle freeze in the middle of a branch stall: 5 held cycles total
    nxt(); lw5_ex(); beq56(1'b0);
    #1 chk("frz_c1", STALLV);
    for (int i = 0; i < 3; i++) begin
      nxt(); dmem_req = 1'b1; mem_read_mem = 1'b1; dest_mem = 5'd5; beq56(1'b0);
      #1 chk("frz_hold", FRZ_STALL);
    end
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b1; mem_read_mem = 1'b1; dest_mem = 5'd5; beq56(1'b0);
    #1 chk("frz_release", STALLS);
    nxt(); beq56(1'b0);
    #1 chk("frz_after", IDLE);
`ifdef PERF_COUNTERS_EN
    chk_cnt("cnt_freeze", freeze_cycles, 32'd3);
`endif

    // jump blocked by a freeze in RUN, then released when dmem_ready rises
    nxt(); jump_id = 1'b1; dmem_req = 1'b1;
    #1 chk("jump_frozen", FRZ_RUN);
    nxt(); jump_id = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b1;
    #1 chk("jump", JMP);
    nxt();
    #1 chk("after_jump", IDLE);
`ifdef PERF_COUNTERS_EN
    chk_cnt("cnt_stall", stall_cycles, 32'd8);
    chk_cnt("cnt_flush", flush_count, 32'd3);
    chk_cnt("cnt_freeze2", freeze_cycles, 32'd4);
`endif

    // jump, then reset asserted mid-STALL
    nxt(); jump_id = 1'b1;
    #1 chk("jump2", JMP);
    nxt(); lw5_ex(); beq56(1'b1);
    #1 chk("pre_reset_c1", STALLV);
    nxt(); mem_read_mem = 1'b1; dest_mem = 5'd5; beq56(1'b1);
    #1 chk("pre_reset_c2", STALLS);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", IDLE);
`ifdef PERF_COUNTERS_EN
    chk_cnt("cnt_rst_stall", stall_cycles, 32'd0);
    chk_cnt("cnt_rst_flush", flush_count, 32'd0);
    chk_cnt("cnt_rst_freeze", freeze_cycles, 32'd0);
`endif
    nxt();
    rst_n = 1'b1;
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; dest_ex = 5'd2; rs_id = 5'd2;
    #1 chk("post_reset_lu", STALLV);
    nxt();
    #1 chk("post_reset_run", IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
